// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vram_pkg
// Brief   : shared types and defaults for the video RAM arbiter
// Revision: 1.0
// ============================================================================
package vram_pkg;

    localparam int c_AW   = 13;
    localparam int c_DW   = 8;
    localparam int c_VLAT = 2;

    // Owner of the read data travelling back through the RAM pipeline
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_CPU  = 2'd2
    } tag_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RD_ISSUE  = 2'd1,
        ST_RD_WAIT   = 2'd2,
        ST_WR_ACCEPT = 2'd3
    } cpu_st_e;

endpackage
`default_nettype wire

// File: rtl/vram_wbuf.sv
`default_nettype none
// ============================================================================
// Module  : vram_wbuf
// Brief   : single-entry posted-write buffer for CPU writes to video RAM
// Revision: 1.0
// ============================================================================
module vram_wbuf
    import vram_pkg::*;
#(
    parameter int AW = c_AW,
    parameter int DW = c_DW
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic          accept_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    input  logic          drain_i,
    output logic          full_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [DW-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (drain_i) begin
            valid_d = 1'b0;
        end
        if (accept_i) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign full_o = valid_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vram_arbiter
// Brief   : shares the video RAM between VGA fetch (highest priority) and CPU
// Revision: 1.0
// ============================================================================
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW   = c_AW,
    parameter int DW   = c_DW,
    parameter int VLAT = c_VLAT
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic          vid_rd_i,
    input  logic [AW-1:0] vid_addr_i,
    output logic [DW-1:0] vid_data_o,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_ack_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_we_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    cpu_st_e       state_q;
    logic          armed_q;
    tag_e          tag_q [VLAT];
    logic [AW-1:0] mem_addr_q;
    logic          mem_we_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] vid_data_q;
    logic [DW-1:0] cpu_rdata_q;
    logic          cpu_ack_q;

    logic          w_wb_full;
    logic [AW-1:0] w_wb_addr;
    logic [DW-1:0] w_wb_data;
    logic          w_drain;
    logic          w_accept;

    assign w_drain  = w_wb_full & ~vid_rd_i;
    assign w_accept = (state_q == ST_WR_ACCEPT) & ~w_wb_full;

    vram_wbuf #(
        .AW (AW),
        .DW (DW)
    ) u_wbuf (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .accept_i  (w_accept),
        .addr_i    (cpu_addr_i),
        .data_i    (cpu_wdata_i),
        .drain_i   (w_drain),
        .full_o    (w_wb_full),
        .addr_o    (w_wb_addr),
        .data_o    (w_wb_data)
    );

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b1;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            vid_data_q  <= '0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            for (int i = 0; i < VLAT; i++) tag_q[i] <= TAG_NONE;
        end else begin
            cpu_ack_q <= 1'b0;
            if (!cpu_req_i) armed_q <= 1'b1;

            for (int i = VLAT - 1; i > 0; i--) tag_q[i] <= tag_q[i-1];
            if (tag_q[VLAT-1] == TAG_VID) vid_data_q <= mem_rdata_i;

            // Slot priority: video, then buffer drain, then CPU read
            mem_we_q <= 1'b0;
            tag_q[0] <= TAG_NONE;
            if (vid_rd_i) begin
                mem_addr_q <= vid_addr_i;
                tag_q[0]   <= TAG_VID;
            end else if (w_wb_full) begin
                mem_addr_q  <= w_wb_addr;
                mem_wdata_q <= w_wb_data;
                mem_we_q    <= 1'b1;
            end else if (state_q == ST_RD_ISSUE) begin
                mem_addr_q <= cpu_addr_i;
                tag_q[0]   <= TAG_CPU;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cpu_req_i && armed_q)
                        state_q <= cpu_we_i ? ST_WR_ACCEPT : ST_RD_ISSUE;
                end
                ST_RD_ISSUE: begin
                    if (!vid_rd_i && !w_wb_full) state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (tag_q[VLAT-1] == TAG_CPU) begin
                        cpu_rdata_q <= mem_rdata_i;
                        cpu_ack_q   <= 1'b1;
                        armed_q     <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_WR_ACCEPT: begin
                    if (!w_wb_full) begin
                        cpu_ack_q <= 1'b1;
                        armed_q   <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign vid_data_o  = vid_data_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign cpu_ack_o   = cpu_ack_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_vram_arbiter
// Brief   : directed self-checking bench for vram_arbiter with a 1-cycle RAM
// Revision: 1.0
// ============================================================================
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vid_rd;
    logic [12:0] vid_addr;
    logic [7:0]  vid_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [12:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [0:8191];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    vram_arbiter dut (
        .clock_i     (clk),
        .reset_n_i   (reset_n),
        .vid_rd_i    (vid_rd),
        .vid_addr_i  (vid_addr),
        .vid_data_o  (vid_data),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_ack_o   (cpu_ack),
        .mem_addr_o  (mem_addr),
        .mem_we_o    (mem_we),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (vid_data !== 8'h00) begin errors++; $display("FAIL rst_vid_data got %h exp 00", vid_data); end
        checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL rst_cpu_rdata got %h exp 00", cpu_rdata); end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_cpu_ack got %b exp 0", cpu_ack); end
        checks++; if (mem_addr !== 13'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0000", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
        checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_mem_wdata got %h exp 00", mem_wdata); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_video();
        logic we_seen;
        we_seen  = 1'b0;
        vid_rd   = 1'b1;
        vid_addr = 13'h0123;
        tick();
        we_seen |= mem_we;
        checks++; if (mem_addr !== 13'h0123) begin errors++; $display("FAIL vid_mem_addr0 got %h exp 0123", mem_addr); end
        vid_addr = 13'h1923;
        tick();
        we_seen |= mem_we;
        checks++; if (mem_addr !== 13'h1923) begin errors++; $display("FAIL vid_mem_addr1 got %h exp 1923", mem_addr); end
        vid_rd = 1'b0;
        tick();
        we_seen |= mem_we;
        checks++; if (vid_data !== 8'hA5) begin errors++; $display("FAIL vid_data0 got %h exp a5", vid_data); end
        tick();
        we_seen |= mem_we;
        checks++; if (vid_data !== 8'h3C) begin errors++; $display("FAIL vid_data1 got %h exp 3c", vid_data); end
        tick();
        we_seen |= mem_we;
        checks++; if (vid_data !== 8'h3C) begin errors++; $display("FAIL vid_data_hold got %h exp 3c", vid_data); end
        checks++; if (we_seen !== 1'b0) begin errors++; $display("FAIL vid_no_we got %b exp 0", we_seen); end
    endtask

    task automatic test_cpu_read();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 13'h0040;
        tick();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_e1 got %b exp 0", cpu_ack); end
        tick();
        checks++; if (mem_addr !== 13'h0040) begin errors++; $display("FAIL rd_mem_addr got %h exp 0040", mem_addr); end
        tick();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_e3 got %b exp 0", cpu_ack); end
        tick();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL rd_ack_e4 got %b exp 1", cpu_ack); end
        checks++; if (cpu_rdata !== 8'h77) begin errors++; $display("FAIL rd_rdata got %h exp 77", cpu_rdata); end
        cpu_req = 1'b0;
        tick();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_pulse got %b exp 0", cpu_ack); end
        tick();
    endtask

    task automatic test_contention();
        vid_rd   = 1'b1;
        vid_addr = 13'h0200;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 13'h0300;
        tick();
        vid_addr = 13'h0201;
        tick();
        checks++; if (mem_addr !== 13'h0201) begin errors++; $display("FAIL ct_vid_slot got %h exp 0201", mem_addr); end
        vid_rd = 1'b0;
        tick();
        checks++; if (mem_addr !== 13'h0300) begin errors++; $display("FAIL ct_rd_issue got %h exp 0300", mem_addr); end
        checks++; if (vid_data !== 8'h11) begin errors++; $display("FAIL ct_vid_data0 got %h exp 11", vid_data); end
        tick();
        checks++; if (vid_data !== 8'h22) begin errors++; $display("FAIL ct_vid_data1 got %h exp 22", vid_data); end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL ct_ack_early got %b exp 0", cpu_ack); end
        tick();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL ct_ack got %b exp 1", cpu_ack); end
        checks++; if (cpu_rdata !== 8'h99) begin errors++; $display("FAIL ct_rdata got %h exp 99", cpu_rdata); end
        checks++; if (vid_data !== 8'h22) begin errors++; $display("FAIL ct_vid_hold got %h exp 22", vid_data); end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 13'h0100;
        cpu_wdata = 8'h55;
        tick();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_early got %b exp 0", cpu_ack); end
        tick();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got %b exp 1", cpu_ack); end
        cpu_req = 1'b0;
        tick();
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_drain_we got %b exp 1", mem_we); end
        checks++; if ({mem_addr, mem_wdata} !== {13'h0100, 8'h55}) begin errors++; $display("FAIL wr_drain_addr_data got %h/%h exp 0100/55", mem_addr, mem_wdata); end
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        tick();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_we_pulse got %b exp 0", mem_we); end
        tick();
        checks++; if (mem_addr !== 13'h0100) begin errors++; $display("FAIL wr_rd_issue got %h exp 0100", mem_addr); end
        tick();
        tick();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL wr_rd_ack got %b exp 1", cpu_ack); end
        checks++; if (cpu_rdata !== 8'h55) begin errors++; $display("FAIL wr_rd_data got %h exp 55", cpu_rdata); end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_buffer_full();
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 13'h0400;
        cpu_wdata = 8'hAA;
        tick();
        tick();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL bf_ack1 got %b exp 1", cpu_ack); end
        cpu_req  = 1'b0;
        vid_rd   = 1'b1;
        vid_addr = 13'h0010;
        tick();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL bf_no_drain0 got %b exp 0", mem_we); end
        cpu_req   = 1'b1;
        cpu_addr  = 13'h0401;
        cpu_wdata = 8'hBB;
        vid_addr  = 13'h0011;
        tick();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL bf_no_drain1 got %b exp 0", mem_we); end
        vid_rd = 1'b0;
        tick();
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 13'h0400, 8'hAA}) begin errors++; $display("FAIL bf_drain1 got %b/%h/%h exp 1/0400/aa", mem_we, mem_addr, mem_wdata); end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL bf_ack2_held got %b exp 0", cpu_ack); end
        checks++; if (vid_data !== 8'hE1) begin errors++; $display("FAIL bf_vid_data0 got %h exp e1", vid_data); end
        tick();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL bf_ack2 got %b exp 1", cpu_ack); end
        checks++; if (vid_data !== 8'hE2) begin errors++; $display("FAIL bf_vid_data1 got %h exp e2", vid_data); end
        cpu_req = 1'b0;
        tick();
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 13'h0401, 8'hBB}) begin errors++; $display("FAIL bf_drain2 got %b/%h/%h exp 1/0401/bb", mem_we, mem_addr, mem_wdata); end
        tick();
        tick();
        checks++; if ({ram[13'h0400], ram[13'h0401]} !== 16'hAABB) begin errors++; $display("FAIL bf_ram got %h%h exp aabb", ram[13'h0400], ram[13'h0401]); end
    endtask

    task automatic test_edge_qual();
        int acks;
        acks     = 0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 13'h0040;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cpu_ack === 1'b1) acks++;
        end
        checks++; if (acks !== 1) begin errors++; $display("FAIL eq_single_ack got %0d exp 1", acks); end
        checks++; if (cpu_rdata !== 8'h77) begin errors++; $display("FAIL eq_rdata got %h exp 77", cpu_rdata); end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int acks;
        acks     = 0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 13'h0040;
        tick();
        tick();
        checks++; if (mem_addr !== 13'h0040) begin errors++; $display("FAIL rm_issue got %h exp 0040", mem_addr); end
        reset_n = 1'b0;
        #1;
        checks++; if ({vid_data, cpu_rdata, cpu_ack, mem_addr, mem_we, mem_wdata} !== 39'h0) begin errors++; $display("FAIL rm_async_clear got %h/%h/%b/%h/%b/%h exp all 0", vid_data, cpu_rdata, cpu_ack, mem_addr, mem_we, mem_wdata); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cpu_ack === 1'b1) acks++;
        end
        reset_n = 1'b1;
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cpu_ack === 1'b1) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL rm_no_ack got %0d exp 0", acks); end
        vid_rd   = 1'b1;
        vid_addr = 13'h0123;
        tick();
        vid_rd = 1'b0;
        tick();
        tick();
        checks++; if (vid_data !== 8'hA5) begin errors++; $display("FAIL rm_vid_after got %h exp a5", vid_data); end
    endtask

    initial begin
        reset_n   = 1'b0;
        vid_rd    = 1'b0;
        vid_addr  = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
        ram[13'h0123] = 8'hA5;
        ram[13'h1923] = 8'h3C;
        ram[13'h0040] = 8'h77;
        ram[13'h0200] = 8'h11;
        ram[13'h0201] = 8'h22;
        ram[13'h0300] = 8'h99;
        ram[13'h0010] = 8'hE1;
        ram[13'h0011] = 8'hE2;

        test_reset();
        test_video();
        test_cpu_read();
        test_contention();
        test_write_read();
        test_buffer_full();
        test_edge_qual();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
